// File: rtl/triangle_stream_monitor_pkg.sv
// rtl/triangle_stream_monitor_pkg.sv - shared types and defaults for the triangle stream monitor
package triangle_pkg;

   localparam int WIDTH_DEF   = 4;
   localparam int MAX_VAL_DEF = 7;
   localparam int ERR_W_DEF   = 8;
   localparam int PER_W_DEF   = 8;

   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      HUNT   = 3'd1,
      RISE   = 3'd2,
      PEAK   = 3'd3,
      FALL   = 3'd4,
      TROUGH = 3'd5
   } state_e;

endpackage

// File: rtl/triangle_stream_monitor_if.sv
// rtl/triangle_stream_monitor_if.sv - sample stream in, health status out
interface triangle_stream_monitor_if
   import triangle_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ERR_W = ERR_W_DEF,
   parameter int PER_W = PER_W_DEF
);
   logic             clear;
   logic             sample_valid;
   logic [WIDTH-1:0] sample;
   logic             locked;
   logic             dir_up;
   logic             peak_pulse;
   logic             trough_pulse;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
   logic [PER_W-1:0] period_count;
   logic             period_valid;

   modport master (
      output clear, sample_valid, sample,
      input  locked, dir_up, peak_pulse, trough_pulse, err_pulse,
             err_count, period_count, period_valid
   );

   modport slave (
      input  clear, sample_valid, sample,
      output locked, dir_up, peak_pulse, trough_pulse, err_pulse,
             err_count, period_count, period_valid
   );
endinterface

// File: rtl/triangle_stream_monitor_sat_counter.sv
// rtl/triangle_stream_monitor_sat_counter.sv - saturating up-counter with sync clear
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/triangle_stream_monitor.sv
// rtl/triangle_stream_monitor.sv - lock/health checker for a 0..MAX..0 triangle count stream
module triangle_stream_monitor
   import triangle_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int MAX_VAL = MAX_VAL_DEF,
   parameter int ERR_W   = ERR_W_DEF,
   parameter int PER_W   = PER_W_DEF
) (
   input logic                     clk,
   input logic                     reset,
   triangle_stream_monitor_if.slave mon
);
   localparam logic [2:0] ST_EMPTY  = EMPTY;
   localparam logic [2:0] ST_HUNT   = HUNT;
   localparam logic [2:0] ST_RISE   = RISE;
   localparam logic [2:0] ST_PEAK   = PEAK;
   localparam logic [2:0] ST_FALL   = FALL;
   localparam logic [2:0] ST_TROUGH = TROUGH;

   localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] MAX_M1 = (WIDTH+1)'(MAX_VAL - 1);
   localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

   logic [2:0]       state, state_nx;
   logic [WIDTH-1:0] prev;
   logic             per_armed;
   logic             locked_r, dir_up_r;
   logic             peak_r, trough_r, err_r, pv_r;
   logic [PER_W-1:0] period_r;
   logic [PER_W-1:0] per_cnt, per_sum;
   logic [ERR_W-1:0] err_cnt;
   logic             peak_evt, trough_evt, err_evt;

   // One extra bit so prev-1 at zero and prev+1 at all-ones can never match a sample
   logic [WIDTH:0] s_x, p_x, p_inc, p_dec;
   logic           hold, at_max, at_zero;

   assign s_x     = {1'b0, mon.sample};
   assign p_x     = {1'b0, prev};
   assign p_inc   = p_x + ONE_X;
   assign p_dec   = p_x - ONE_X;
   assign hold    = (s_x == p_x);
   assign at_max  = (p_x == MAX_X);
   assign at_zero = (p_x == '0);

   always_comb begin
      state_nx   = state;
      peak_evt   = 1'b0;
      trough_evt = 1'b0;
      err_evt    = 1'b0;
      case (state)
         ST_EMPTY: state_nx = ST_HUNT;
         ST_HUNT: begin
            if (s_x == p_inc)          state_nx = ST_RISE;
            else if (s_x == p_dec)     state_nx = ST_FALL;
            else if (hold && at_zero)  state_nx = ST_TROUGH;
            else if (hold && at_max)   state_nx = ST_PEAK;
         end
         ST_RISE: begin
            if ((s_x == p_inc) && (s_x <= MAX_X)) begin
               state_nx = ST_RISE;
            end else if (hold && at_max) begin
               state_nx = ST_PEAK;
               peak_evt = 1'b1;
            end else begin
               err_evt = 1'b1;
            end
         end
         ST_PEAK: begin
            if (s_x == MAX_M1) state_nx = ST_FALL;
            else               err_evt  = 1'b1;
         end
         ST_FALL: begin
            if (s_x == p_dec) begin
               state_nx = ST_FALL;
            end else if (hold && at_zero) begin
               state_nx   = ST_TROUGH;
               trough_evt = 1'b1;
            end else begin
               err_evt = 1'b1;
            end
         end
         ST_TROUGH: begin
            if (s_x == ONE_X) state_nx = ST_RISE;
            else              err_evt  = 1'b1;
         end
         default: state_nx = ST_HUNT;
      endcase
      if (err_evt) state_nx = ST_HUNT;
   end

   assign per_sum = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_EMPTY;
         prev      <= '0;
         per_armed <= 1'b0;
         locked_r  <= 1'b0;
         dir_up_r  <= 1'b0;
         peak_r    <= 1'b0;
         trough_r  <= 1'b0;
         err_r     <= 1'b0;
         pv_r      <= 1'b0;
         period_r  <= '0;
      end else if (mon.clear) begin
         state     <= ST_EMPTY;
         prev      <= '0;
         per_armed <= 1'b0;
         locked_r  <= 1'b0;
         dir_up_r  <= 1'b0;
         peak_r    <= 1'b0;
         trough_r  <= 1'b0;
         err_r     <= 1'b0;
         pv_r      <= 1'b0;
         period_r  <= '0;
      end else begin
         peak_r   <= 1'b0;
         trough_r <= 1'b0;
         err_r    <= 1'b0;
         pv_r     <= 1'b0;
         if (mon.sample_valid) begin
            state    <= state_nx;
            prev     <= mon.sample;
            peak_r   <= peak_evt;
            trough_r <= trough_evt;
            err_r    <= err_evt;
            dir_up_r <= (state_nx == ST_RISE);
            if (err_evt) begin
               locked_r  <= 1'b0;
               per_armed <= 1'b0;
            end else if (peak_evt || trough_evt) begin
               locked_r <= 1'b1;
            end
            if (trough_evt) begin
               per_armed <= 1'b1;
               if (per_armed) begin
                  period_r <= per_sum;
                  pv_r     <= 1'b1;
               end
            end
         end
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (mon.clear),
      .inc   (mon.sample_valid && err_evt),
      .count (err_cnt)
   );

   // Restarts on every legal trough so the next trough sees the full period length
   sat_counter #(.W(PER_W)) u_per_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (mon.clear || (mon.sample_valid && trough_evt)),
      .inc   (mon.sample_valid),
      .count (per_cnt)
   );

   assign mon.locked       = locked_r;
   assign mon.dir_up       = dir_up_r;
   assign mon.peak_pulse   = peak_r;
   assign mon.trough_pulse = trough_r;
   assign mon.err_pulse    = err_r;
   assign mon.err_count    = err_cnt;
   assign mon.period_count = period_r;
   assign mon.period_valid = pv_r;
endmodule

// File: tb/tb_triangle_stream_monitor.sv
// tb/tb_triangle_stream_monitor.sv - directed vector bench for triangle_stream_monitor
module tb_triangle_stream_monitor;
   import triangle_pkg::*;

   typedef struct {
      logic        v;
      logic [3:0]  s;
      logic [21:0] exp;
   } vec_t;

   logic  clk = 1'b0;
   logic  reset = 1'b1;
   int    checks = 0;
   int    failures = 0;
   vec_t  tbl[$];
   logic [21:0] act;

   triangle_stream_monitor_if #(.WIDTH(4), .ERR_W(8), .PER_W(8)) bus ();

   triangle_stream_monitor #(.WIDTH(4), .MAX_VAL(7), .ERR_W(8), .PER_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus)
   );

   always #5 clk = ~clk;

   // {peak, trough, err, locked, dir_up, period_valid, period_count, err_count}
   assign act = {bus.peak_pulse, bus.trough_pulse, bus.err_pulse, bus.locked, bus.dir_up,
                 bus.period_valid, bus.period_count, bus.err_count};

   task automatic add(input logic v, input int s, input logic pk, input logic tr, input logic er,
                      input logic lk, input logic du, input logic pv, input int pc, input int ec);
      vec_t r;
      r.v   = v;
      r.s   = s[3:0];
      r.exp = {pk, tr, er, lk, du, pv, 8'(pc), 8'(ec)};
      tbl.push_back(r);
   endtask

   task automatic check(input string name, input logic [21:0] a, input logic [21:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, a, e);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] s, input logic clr);
      @(negedge clk);
      bus.sample_valid = v;
      bus.sample       = s;
      bus.clear        = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pc;
      int ec;
      bus.clear = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample = '0;

      // First lock: no period yet
      add(1, 0, 0,0,0,0,0,0, 0,0);
      for (int s = 1; s <= 7; s++) add(1, s, 0,0,0,0,1,0, 0,0);
      add(1, 7, 1,0,0,1,0,0, 0,0);
      for (int s = 6; s >= 0; s--) add(1, s, 0,0,0,1,0,0, 0,0);
      add(1, 0, 0,1,0,1,0,0, 0,0);
      // Two more full periods, period 16 at each trough
      for (int p = 0; p < 2; p++) begin
         pc = (p == 0) ? 0 : 16;
         for (int s = 1; s <= 7; s++) add(1, s, 0,0,0,1,1,0, pc,0);
         add(1, 7, 1,0,0,1,0,0, pc,0);
         for (int s = 6; s >= 0; s--) add(1, s, 0,0,0,1,0,0, pc,0);
         add(1, 0, 0,1,0,1,0,1, 16,0);
      end
      // Jump in RISE, resync, relock at peak
      add(1, 1, 0,0,0,1,1,0, 16,0);
      add(1, 2, 0,0,0,1,1,0, 16,0);
      add(1, 3, 0,0,0,1,1,0, 16,0);
      add(1, 5, 0,0,1,0,0,0, 16,1);
      add(1, 6, 0,0,0,0,1,0, 16,1);
      add(1, 7, 0,0,0,0,1,0, 16,1);
      add(1, 7, 1,0,0,1,0,0, 16,1);
      // Third 7 at peak, then a hold at 2 while falling
      add(1, 7, 0,0,1,0,0,0, 16,2);
      for (int s = 6; s >= 2; s--) add(1, s, 0,0,0,0,0,0, 16,2);
      add(1, 2, 0,0,1,0,0,0, 16,3);
      // Relock without period (unarmed), then a period with a valid gap mid-FALL
      add(1, 1, 0,0,0,0,0,0, 16,3);
      add(1, 0, 0,0,0,0,0,0, 16,3);
      add(1, 0, 0,1,0,1,0,0, 16,3);
      for (int s = 1; s <= 7; s++) add(1, s, 0,0,0,1,1,0, 16,3);
      add(1, 7, 1,0,0,1,0,0, 16,3);
      add(1, 6, 0,0,0,1,0,0, 16,3);
      add(1, 5, 0,0,0,1,0,0, 16,3);
      for (int k = 0; k < 5; k++) add(0, 9, 0,0,0,1,0,0, 16,3);
      for (int s = 4; s >= 0; s--) add(1, s, 0,0,0,1,0,0, 16,3);
      add(1, 0, 0,1,0,1,0,1, 16,3);

      // Reset state
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset_state", act, 22'h0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].s, 1'b0);
         check($sformatf("vec%0d", i), act, tbl[i].exp);
      end

      // Clear with a valid (otherwise erroneous) sample: sample dropped, everything zero
      drive(1'b1, 4'd5, 1'b1);
      check("clear_zero", act, 22'h0);
      drive(1'b1, 4'd9, 1'b0);
      check("post_clear_empty", act, 22'h0);
      drive(1'b1, 4'd3, 1'b0);
      check("post_clear_hunt", act, 22'h0);

      // 300 violations: 0 (HUNT), 1 (RISE), 5 (jump error)
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 4'd0, 1'b0);
         drive(1'b1, 4'd1, 1'b0);
         drive(1'b1, 4'd5, 1'b0);
         ec = (i + 1 > 255) ? 255 : i + 1;
         check($sformatf("sat%0d", i), {act[19], act[7:0]}, {1'b1, 8'(ec)});
      end

      // Lock again, then reset asynchronously mid-RISE
      drive(1'b1, 4'd0, 1'b0);
      for (int s = 1; s <= 7; s++) drive(1'b1, 4'(s), 1'b0);
      drive(1'b1, 4'd7, 1'b0);
      for (int s = 6; s >= 0; s--) drive(1'b1, 4'(s), 1'b0);
      drive(1'b1, 4'd0, 1'b0);
      drive(1'b1, 4'd1, 1'b0);
      drive(1'b1, 4'd2, 1'b0);
      check("pre_reset_locked", act, {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 8'd0, 8'd255});
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", act, 22'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 4'd5, 1'b0);
      drive(1'b1, 4'd12, 1'b0);
      check("post_reset_no_err", act, 22'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
